// File: rtl/timer_ctrl_pkg.sv
// rtl/timer_ctrl_pkg.sv - shared encodings for the timer controller
package timer_ctrl_pkg;
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ARMED = 2'd1;
  localparam logic [1:0] RUN   = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  localparam logic MODE_ONESHOT  = 1'b0;
  localparam logic MODE_PERIODIC = 1'b1;

  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;
endpackage

// File: rtl/timer_ctrl_if.sv
// rtl/timer_ctrl_if.sv - configuration handshake between front end and timer
interface timer_ctrl_if #(parameter int N = 8);
  logic         cfg_valid;
  logic         cfg_ready;
  logic [N-1:0] cfg_load;
  logic         cfg_mode;
  logic         cfg_dir;

  modport master (output cfg_valid, cfg_load, cfg_mode, cfg_dir, input cfg_ready);
  modport slave  (input cfg_valid, cfg_load, cfg_mode, cfg_dir, output cfg_ready);
endinterface

// File: rtl/timer_ctrl_updown_counter.sv
// rtl/timer_ctrl_updown_counter.sv - loadable up/down counter, load beats enable
module updown_counter #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         en,
  input  logic         dir,
  input  logic         load,
  input  logic [N-1:0] load_val,
  output logic [N-1:0] q
);
  import timer_ctrl_pkg::*;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      q <= '0;
    end else if (load) begin
      q <= load_val;
    end else if (en) begin
      q <= (dir == DIR_DOWN) ? q - N'(1) : q + N'(1);
    end
  end
endmodule

// File: rtl/timer_ctrl.sv
// rtl/timer_ctrl.sv - timer sequencer: config latch, FSM, terminal compare
module timer_ctrl #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         reset_n,
  timer_ctrl_if.slave  cfg,
  input  logic         start,
  input  logic         stop,
  output logic [N-1:0] count,
  output logic         busy,
  output logic         tick,
  output logic         done
);
  import timer_ctrl_pkg::*;

  logic [1:0]   state, state_nx;
  logic [N-1:0] load_r;
  logic         mode_r, dir_r;
  logic         cfg_take, at_term;
  logic         cnt_load, cnt_en;
  logic [N-1:0] cnt_val, start_val, term_val, new_start;

  assign cfg.cfg_ready = (state == IDLE) || (state == DONE);
  assign cfg_take      = cfg.cfg_valid && cfg.cfg_ready && !stop;

  assign start_val = (dir_r == DIR_DOWN) ? load_r : '0;
  assign term_val  = (dir_r == DIR_DOWN) ? '0 : load_r;
  assign new_start = (cfg.cfg_dir == DIR_DOWN) ? cfg.cfg_load : '0;
  assign at_term   = (count == term_val);

  assign busy = (state == RUN);
  assign tick = busy && at_term;
  assign done = (state == DONE);

  // stop > cfg accept > start > counting/terminal
  always_comb begin
    state_nx = state;
    cnt_load = 1'b0;
    cnt_en   = 1'b0;
    cnt_val  = start_val;
    if (stop) begin
      state_nx = IDLE;
      cnt_load = 1'b1;
      cnt_val  = '0;
    end else if (cfg_take) begin
      state_nx = ARMED;
      cnt_load = 1'b1;
      cnt_val  = new_start;
    end else begin
      case (state)
        ARMED: if (start) state_nx = RUN;
        RUN: begin
          if (at_term) begin
            if (mode_r == MODE_ONESHOT) state_nx = DONE;
            else                        cnt_load = 1'b1;
          end else begin
            cnt_en = 1'b1;
          end
        end
        DONE: begin
          if (start) begin
            state_nx = RUN;
            cnt_load = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= IDLE;
      load_r <= '0;
      mode_r <= MODE_ONESHOT;
      dir_r  <= DIR_UP;
    end else begin
      state <= state_nx;
      if (cfg_take) begin
        load_r <= cfg.cfg_load;
        mode_r <= cfg.cfg_mode;
        dir_r  <= cfg.cfg_dir;
      end
    end
  end

  updown_counter #(.N(N)) u_cnt (
    .clk      (clk),
    .reset_n  (reset_n),
    .en       (cnt_en),
    .dir      (dir_r),
    .load     (cnt_load),
    .load_val (cnt_val),
    .q        (count)
  );
endmodule

// File: tb/tb_timer_ctrl.sv
// tb/tb_timer_ctrl.sv - scoreboard bench for timer_ctrl
module tb_timer_ctrl;
  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic [7:0] count;
  logic       busy, tick, done;
  int         cyc_count = 0;
  int         n_tests = 0;
  int         n_fail = 0;

  timer_ctrl_if #(.N(8)) cfg_if ();

  timer_ctrl #(.N(8)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .cfg     (cfg_if.slave),
    .start   (start),
    .stop    (stop),
    .count   (count),
    .busy    (busy),
    .tick    (tick),
    .done    (done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc_count <= cyc_count + 1;

  typedef struct {
    int          cyc;
    logic [11:0] v;
    string       nm;
  } exp_t;

  exp_t sb[$];

  task automatic push_exp(input int cyc, input logic [7:0] c, input logic b, t, d, r,
                          input string nm);
    exp_t e;
    e.cyc = cyc;
    e.v   = {c, b, t, d, r};
    e.nm  = nm;
    sb.push_back(e);
  endtask

  task automatic step(input logic [7:0] c, input logic b, t, d, r, input string nm);
    push_exp(cyc_count + 1, c, b, t, d, r, nm);
    @(posedge clk);
    #1;
  endtask

  task automatic set_cfg(input logic [7:0] l, input logic m, input logic dr);
    cfg_if.cfg_valid = 1'b1;
    cfg_if.cfg_load  = l;
    cfg_if.cfg_mode  = m;
    cfg_if.cfg_dir   = dr;
  endtask

  // monitor: compares every expectation whose cycle has been reached
  initial begin
    exp_t        e;
    logic [11:0] act;
    forever begin
      @(negedge clk or negedge reset_n);
      #1;
      while (sb.size() > 0 && sb[0].cyc <= cyc_count) begin
        e   = sb.pop_front();
        act = {count, busy, tick, done, cfg_if.cfg_ready};
        n_tests++;
        if (act !== e.v) begin
          n_fail++;
          $display("FAIL %s: got count=%0d busy=%b tick=%b done=%b ready=%b, expected count=%0d busy=%b tick=%b done=%b ready=%b",
                   e.nm, act[11:4], act[3], act[2], act[1], act[0],
                   e.v[11:4], e.v[3], e.v[2], e.v[1], e.v[0]);
        end
      end
    end
  end

  initial begin
    cfg_if.cfg_valid = 1'b0;
    cfg_if.cfg_load  = 8'd0;
    cfg_if.cfg_mode  = 1'b0;
    cfg_if.cfg_dir   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    push_exp(cyc_count, 8'd0, 0, 0, 0, 1, "reset_state");
    reset_n = 1'b1;

    // start ignored in IDLE
    start = 1'b1;
    step(8'd0, 0, 0, 0, 1, "idle_start_ignored");
    start = 1'b0;

    // up one-shot L=5
    set_cfg(8'd5, 1'b0, 1'b0);
    step(8'd0, 0, 0, 0, 0, "up5_armed");
    cfg_if.cfg_valid = 1'b0;
    step(8'd0, 0, 0, 0, 0, "up5_armed_hold");
    start = 1'b1;
    step(8'd0, 1, 0, 0, 0, "up5_run0");
    start = 1'b0;
    for (int i = 1; i <= 5; i++) step(8'(i), 1, (i == 5), 0, 0, "up5_run");
    step(8'd5, 0, 0, 1, 1, "up5_done");
    step(8'd5, 0, 0, 1, 1, "up5_done_hold");

    // down periodic L=3, accepted from DONE
    set_cfg(8'd3, 1'b1, 1'b1);
    step(8'd3, 0, 0, 0, 0, "dn3_armed");
    cfg_if.cfg_valid = 1'b0;
    start = 1'b1;
    step(8'd3, 1, 0, 0, 0, "dn3_run0");
    start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      automatic logic [7:0] c = 8'(2 - (i % 4));
      if (i % 4 == 3) c = 8'd3;
      step(c, 1, (c == 8'd0), 0, 0, "dn3_periodic");
    end
    stop = 1'b1;
    step(8'd0, 0, 0, 0, 1, "dn3_stop");
    stop = 1'b0;

    // up L=7, stop at count 2
    set_cfg(8'd7, 1'b0, 1'b0);
    step(8'd0, 0, 0, 0, 0, "up7_armed");
    cfg_if.cfg_valid = 1'b0;
    start = 1'b1;
    step(8'd0, 1, 0, 0, 0, "up7_run0");
    start = 1'b0;
    step(8'd1, 1, 0, 0, 0, "up7_run1");
    step(8'd2, 1, 0, 0, 0, "up7_run2");
    stop = 1'b1;
    step(8'd0, 0, 0, 0, 1, "up7_stop");
    stop = 1'b0;
    step(8'd0, 0, 0, 0, 1, "up7_idle");

    // L=0 one-shot then periodic
    set_cfg(8'd0, 1'b0, 1'b0);
    step(8'd0, 0, 0, 0, 0, "l0_os_armed");
    cfg_if.cfg_valid = 1'b0;
    start = 1'b1;
    step(8'd0, 1, 1, 0, 0, "l0_os_tick");
    start = 1'b0;
    step(8'd0, 0, 0, 1, 1, "l0_os_done");
    set_cfg(8'd0, 1'b1, 1'b0);
    step(8'd0, 0, 0, 0, 0, "l0_per_armed");
    cfg_if.cfg_valid = 1'b0;
    start = 1'b1;
    step(8'd0, 1, 1, 0, 0, "l0_per_tick0");
    start = 1'b0;
    for (int i = 0; i < 3; i++) step(8'd0, 1, 1, 0, 0, "l0_per_tick");
    stop = 1'b1;
    step(8'd0, 0, 0, 0, 1, "l0_per_stop");
    stop = 1'b0;

    // start and stop together in ARMED: stop wins
    set_cfg(8'd6, 1'b0, 1'b1);
    step(8'd6, 0, 0, 0, 0, "ss_armed");
    cfg_if.cfg_valid = 1'b0;
    start = 1'b1;
    stop  = 1'b1;
    step(8'd0, 0, 0, 0, 1, "ss_stop_wins");
    start = 1'b0;
    stop  = 1'b0;

    // up L=4 one-shot, rerun from DONE, cfg ignored during RUN
    set_cfg(8'd4, 1'b0, 1'b0);
    step(8'd0, 0, 0, 0, 0, "up4_armed");
    cfg_if.cfg_valid = 1'b0;
    start = 1'b1;
    step(8'd0, 1, 0, 0, 0, "up4_run0");
    start = 1'b0;
    for (int i = 1; i <= 4; i++) step(8'(i), 1, (i == 4), 0, 0, "up4_run");
    step(8'd4, 0, 0, 1, 1, "up4_done");
    start = 1'b1;
    step(8'd0, 1, 0, 0, 0, "up4_rerun0");
    start = 1'b0;
    step(8'd1, 1, 0, 0, 0, "up4_rerun1");
    set_cfg(8'd9, 1'b1, 1'b1);
    step(8'd2, 1, 0, 0, 0, "up4_cfg_ignored");
    cfg_if.cfg_valid = 1'b0;
    step(8'd3, 1, 0, 0, 0, "up4_rerun3");
    step(8'd4, 1, 1, 0, 0, "up4_rerun_tick");
    step(8'd4, 0, 0, 1, 1, "up4_redone");
    set_cfg(8'd2, 1'b0, 1'b1);
    step(8'd2, 0, 0, 0, 0, "dn2_armed");
    cfg_if.cfg_valid = 1'b0;

    // stop coinciding with tick goes to IDLE
    start = 1'b1;
    step(8'd2, 1, 0, 0, 0, "dn2_run0");
    start = 1'b0;
    step(8'd1, 1, 0, 0, 0, "dn2_run1");
    step(8'd0, 1, 1, 0, 0, "dn2_tick");
    stop = 1'b1;
    step(8'd0, 0, 0, 0, 1, "dn2_stop_on_tick");
    stop = 1'b0;

    // asynchronous reset mid-RUN at count 3
    set_cfg(8'd7, 1'b1, 1'b0);
    step(8'd0, 0, 0, 0, 0, "rst_armed");
    cfg_if.cfg_valid = 1'b0;
    start = 1'b1;
    step(8'd0, 1, 0, 0, 0, "rst_run0");
    start = 1'b0;
    for (int i = 1; i <= 3; i++) step(8'(i), 1, 0, 0, 0, "rst_run");
    @(negedge clk);
    #2;
    push_exp(cyc_count, 8'd0, 0, 0, 0, 1, "async_reset");
    reset_n = 1'b0;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    start = 1'b1;
    step(8'd0, 0, 0, 0, 1, "post_reset_start_ignored");
    start = 1'b0;
    step(8'd0, 0, 0, 0, 1, "post_reset_idle");

    for (int i = 0; i < 20 && sb.size() > 0; i++) @(posedge clk);
    if (sb.size() > 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain: %0d expectations left unchecked, required 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/timer_ctrl.md
# timer_ctrl

Programmable timer controller that sequences a synchronous up/down counter. It accepts a configuration through a valid/ready handshake, then runs the counter on start in one-shot or periodic mode. It flags terminal count and completion, and aborts on stop. It sits between a software/config front end and the counter datapath, replacing free-running ripple counting wherever a bounded, restartable count is needed.

## Interface
- N, 8: counter width in bits (N ≥ 2).
- clk  input  1  single clock; all state changes on rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- cfg_valid  input  1  configuration offered.
- cfg_ready  output  1  configuration can be accepted (state IDLE or DONE).
- cfg_load  input  N  terminal/start value L.
- cfg_mode  input  1  0 = one-shot, 1 = periodic.
- cfg_dir  input  1  0 = up (0→L), 1 = down (L→0).
- start  input  1  begin/restart counting (single-cycle pulse or level; sampled per cycle).
- stop  input  1  abort and return to IDLE.
- count  output  N  current counter value.
- busy  output  1  high in state RUN.
- tick  output  1  high for the RUN cycle in which count equals the terminal value.
- done  output  1  high in state DONE.

## Operation
- States: IDLE, ARMED, RUN, DONE.
- Start value S and terminal value T:
  - Up: S = 0, T = L.
  - Down: S = L, T = 0.
- IDLE:
  - cfg_valid & cfg_ready latches L, mode, dir; count ← S; go to ARMED.
  - start is ignored.
- ARMED:
  - start → RUN; count holds S.
  - stop → IDLE; count ← 0.
  - cfg_ready is low.
- RUN:
  - Each cycle: count ± 1 (mod 2^N, though wrap cannot occur before T).
  - When count == T: tick = 1.
    - One-shot: next state DONE, count holds T.
    - Periodic: count ← S, stay RUN.
  - stop → IDLE, count ← 0.
- DONE:
  - done = 1 and count holds T.
  - start → RUN with count ← S, reusing the latched configuration.
  - A new config is accepted → ARMED with count ← new S.
- Priority: reset_n > stop > cfg accept > start > counting/terminal.
  - When stop coincides with count == T in RUN, tick is still 1 that cycle, but the next state is IDLE, not DONE or reload.
  - start and stop in the same cycle: stop wins.
- cfg_valid outside IDLE/DONE is ignored; nothing is latched.
- L = 0: T == S, so the first RUN cycle is terminal.
  - One-shot: tick in the first RUN cycle, then DONE.
  - Periodic: tick every cycle.
- Outputs decode from registered state/count only (Moore); no input-to-output combinational paths except cfg_ready, which is state-only.

## Timing
- Reset values: state IDLE, count 0, cfg_ready 1, busy 0, tick 0, done 0, latched L/mode/dir = 0.
- Config accepted at edge k: ARMED and count = S visible after edge k.
- start sampled at edge m in ARMED or DONE: busy = 1 after edge m, with count = S.
  - The first increment/decrement occurs at edge m+1.
- tick asserts in RUN-cycle index L (0-based) after entering RUN.
  - The period in periodic mode is L+1 cycles.
  - One-shot: done rises at the edge ending the tick cycle.
- stop sampled at edge j: IDLE, count = 0, busy = 0 after edge j.
- Reset assertion mid-operation forces reset values immediately (asynchronous).
  - Deassertion is assumed synchronised externally.

## Structure
- Package timer_ctrl_pkg holds:
  - State encoding constants: IDLE = 2'd0, ARMED = 2'd1, RUN = 2'd2, DONE = 2'd3.
  - Mode constants: MODE_ONESHOT = 0, MODE_PERIODIC = 1.
  - Direction constants: DIR_UP = 0, DIR_DOWN = 1.
- Sub-module updown_counter #(N):
  - Inputs: clk, reset_n, en, dir, load, load_val[N-1:0].
  - Output: q[N-1:0].
  - Load has priority over en.
- timer_ctrl contains the FSM, configuration registers, terminal compare and output decode.

## Test plan
- Up one-shot, L = 5, start one cycle after config:
  - count 0,1,2,3,4,5 over 6 busy cycles.
  - tick exactly at count 5.
  - done = 1 next cycle; count holds 5.
- Down periodic, L = 3:
  - count 3,2,1,0,3,2,1,0…
  - tick every 4th cycle at count 0.
  - done stays 0.
- stop asserted at count 2 of an up run with L = 7:
  - IDLE next cycle; count = 0, busy = 0, tick never seen.
  - cfg_ready = 1.
- L = 0:
  - One-shot gives one tick in the first RUN cycle, then DONE.
  - Periodic gives tick continuously until stop.
- In DONE after up L = 4:
  - start reruns 0..4 with tick again.
  - A new config (down, L = 2) yields ARMED with count = 2.
  - cfg_valid during RUN is ignored (cfg_ready = 0, config unchanged).
- reset_n pulsed low mid-RUN at count 3:
  - All outputs return to reset values without a clock edge.
  - After release, start alone stays in IDLE.
